// File: rtl/rr_priority_arbiter.sv
// Rotating-priority arbiter: one registered one-hot grant among N requesters,
// held while requested, with an optional hold limit under contention.
module rr_priority_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           preempt
);

    localparam int HCW = $clog2(MAX_HOLD) + 1;
    localparam logic [HCW-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);
    localparam logic [N-1:0] ONE = 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [HCW-1:0] hold_cnt;

    // Returns {found, index} of the first set bit scanning upward from start.
    function automatic logic [IDW:0] pick(
        input logic [N-1:0]   cand,
        input logic [IDW-1:0] start
    );
        logic           found;
        logic [IDW-1:0] idx;
        logic [IDW-1:0] k_idx;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            k_idx = start + IDW'(k);
            if (!found && cand[k_idx]) begin
                found = 1'b1;
                idx   = k_idx;
            end
        end
        return {found, idx};
    endfunction

    logic [N-1:0]   others;
    logic [IDW-1:0] next_ptr;
    logic [IDW:0]   fresh;
    logic [IDW:0]   handoff;
    logic           held;
    logic           timeout;

    assign others   = req & ~grant;
    assign next_ptr = grant_id + IDW'(1);
    assign fresh    = pick(req, ptr);
    assign handoff  = pick(others, next_ptr);
    assign held     = |(req & grant);
    assign timeout  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && (|others);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            preempt     <= 1'b0;
            ptr         <= '0;
            hold_cnt    <= '0;
        end else begin
            preempt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fresh[IDW]) begin
                        grant       <= ONE << fresh[IDW-1:0];
                        grant_id    <= fresh[IDW-1:0];
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (!held || timeout) begin
                        // Release wins over timeout, so preempt only when still held.
                        ptr      <= next_ptr;
                        hold_cnt <= '0;
                        preempt  <= held;
                        if (handoff[IDW]) begin
                            grant       <= ONE << handoff[IDW-1:0];
                            grant_id    <= handoff[IDW-1:0];
                            grant_valid <= 1'b1;
                        end else begin
                            grant       <= '0;
                            grant_id    <= '0;
                            grant_valid <= 1'b0;
                            state       <= IDLE;
                        end
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
